// File: rtl/s_to_p_pkg.sv
// Shared types for the serial/parallel word converters.
package s_to_p_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

endpackage

// File: rtl/beat_counter.sv
// Modulo-N beat counter; last flags the final beat of a frame.
module beat_counter
    import s_to_p_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/s_to_p_converter.sv
// Serial-to-parallel word assembler: packs N_BEATS input beats into one output frame,
// either as a single-cycle pulse (fct=1) or held until ordy (fct=0).
module s_to_p_converter
    import s_to_p_pkg::*;
#(
    parameter int SERIAL_LENGTH   = 2,
    parameter int PARALLEL_LENGTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ien,
    input  logic [0:SERIAL_LENGTH-1][31:0]    idata,
    input  logic                              fct,
    input  logic                              ordy,
    output logic                              oen,
    output logic [0:PARALLEL_LENGTH-1][31:0]  odata,
    output logic                              full
);

    localparam int N_BEATS = PARALLEL_LENGTH / SERIAL_LENGTH;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    generate
        if (SERIAL_LENGTH < 1 || (PARALLEL_LENGTH % SERIAL_LENGTH) != 0) begin : g_bad_params
            $error("PARALLEL_LENGTH must be a positive multiple of SERIAL_LENGTH");
        end
    endgenerate

    state_t                      state;
    state_t                      state_next;
    logic [CNT_W-1:0]            cnt;
    logic                        last;
    logic                        accept;
    logic                        complete;
    word_t [0:PARALLEL_LENGTH-1] abuf;
    word_t [0:PARALLEL_LENGTH-1] frame;

    assign accept   = (state == COLLECT) && ien;
    assign complete = accept && last;
    assign full     = (state == HOLD);

    beat_counter #(
        .N (N_BEATS),
        .W (CNT_W)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (1'b0),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Mode is sampled only on the completion beat; HOLD waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (complete && !fct) state_next = HOLD;
            HOLD:    if (ordy)             state_next = COLLECT;
            default:                       state_next = COLLECT;
        endcase
    end

    // The final beat bypasses the buffer so the frame is ready on the completion edge.
    always_comb begin
        frame = abuf;
        frame[(N_BEATS-1)*SERIAL_LENGTH +: SERIAL_LENGTH] = idata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abuf <= '0;
        end else if (accept && !last) begin
            for (int b = 0; b < N_BEATS - 1; b++) begin
                if (cnt == CNT_W'(b)) begin
                    abuf[b*SERIAL_LENGTH +: SERIAL_LENGTH] <= idata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odata <= '0;
            oen   <= 1'b0;
        end else if (complete) begin
            odata <= frame;
            oen   <= 1'b1;
        end else if (state == COLLECT || ordy) begin
            oen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_to_p_converter.sv
// Directed self-checking bench for s_to_p_converter: default geometry plus N_BEATS=1 and SERIAL_LENGTH=1.
module tb_s_to_p_converter;

    logic              clk = 1'b0;
    logic              rst;
    logic              ien, fct, ordy;
    logic [0:1][31:0]  idata;
    logic              oen, full;
    logic [0:3][31:0]  odata;

    logic              ien_n1;
    logic [0:3][31:0]  idata_n1;
    logic              oen_n1, full_n1;
    logic [0:3][31:0]  odata_n1;

    logic              ien_s1;
    logic [0:0][31:0]  idata_s1;
    logic              oen_s1, full_s1;
    logic [0:3][31:0]  odata_s1;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] F_1248  = {32'd1, 32'd2, 32'd4, 32'd8};
    localparam logic [127:0] F_HIGH  = {32'h80000000, 32'h40000000, 32'h20000000, 32'h10000000};
    localparam logic [127:0] F_35711 = {32'd3, 32'd5, 32'd7, 32'd11};
    localparam logic [127:0] F_1122  = {32'd1, 32'd1, 32'd2, 32'd2};

    always #5 clk = ~clk;

    s_to_p_converter #(.SERIAL_LENGTH(2), .PARALLEL_LENGTH(4)) dut (
        .clk(clk), .rst(rst), .ien(ien), .idata(idata), .fct(fct), .ordy(ordy),
        .oen(oen), .odata(odata), .full(full)
    );

    s_to_p_converter #(.SERIAL_LENGTH(4), .PARALLEL_LENGTH(4)) dut_n1 (
        .clk(clk), .rst(rst), .ien(ien_n1), .idata(idata_n1), .fct(1'b1), .ordy(1'b0),
        .oen(oen_n1), .odata(odata_n1), .full(full_n1)
    );

    s_to_p_converter #(.SERIAL_LENGTH(1), .PARALLEL_LENGTH(4)) dut_s1 (
        .clk(clk), .rst(rst), .ien(ien_s1), .idata(idata_s1), .fct(1'b1), .ordy(1'b0),
        .oen(oen_s1), .odata(odata_s1), .full(full_s1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] w0, input logic [31:0] w1);
        ien      = valid;
        idata[0] = w0;
        idata[1] = w1;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; ien = 1'b0; fct = 1'b1; ordy = 1'b0; idata = '0;
        ien_n1 = 1'b0; idata_n1 = '0; ien_s1 = 1'b0; idata_s1 = '0;
        tick();
        tick();
        checkOutput("reset_oen", 128'(oen), 128'(1'b0));
        checkOutput("reset_full", 128'(full), 128'(1'b0));
        checkOutput("reset_odata", odata, 128'd0);

        // Mid-frame reset must discard the partial beat.
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 32'd9, 32'd9);
        ien = 1'b0;
        rst = 1'b1;
        tick();
        checkOutput("midrst_oen", 128'(oen), 128'(1'b0));
        rst = 1'b0;
        applyStimulus(1'b1, 32'd1, 32'd2);
        checkOutput("midrst_first_oen", 128'(oen), 128'(1'b0));
        applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd4, 32'd8);
        checkOutput("midrst_done_oen", 128'(oen), 128'(1'b1));
        checkOutput("midrst_odata", odata, F_1248);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Free-running single frame with idle gaps.
        applyStimulus(1'b1, 32'd1, 32'd2);
        checkOutput("free_beat1_oen", 128'(oen), 128'(1'b0));
        applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd4, 32'd8);
        checkOutput("free_oen", 128'(oen), 128'(1'b1));
        checkOutput("free_full", 128'(full), 128'(1'b0));
        checkOutput("free_odata", odata, F_1248);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("free_pulse_end", 128'(oen), 128'(1'b0));
        checkOutput("free_odata_kept", odata, F_1248);

        // Free-running back-to-back beats.
        applyStimulus(1'b1, 32'd1, 32'd2);
        checkOutput("b2b_b1_oen", 128'(oen), 128'(1'b0));
        applyStimulus(1'b1, 32'd4, 32'd8);
        checkOutput("b2b_f1_oen", 128'(oen), 128'(1'b1));
        checkOutput("b2b_f1_odata", odata, F_1248);
        applyStimulus(1'b1, 32'h80000000, 32'h40000000);
        checkOutput("b2b_b3_oen", 128'(oen), 128'(1'b0));
        applyStimulus(1'b1, 32'h20000000, 32'h10000000);
        checkOutput("b2b_f2_oen", 128'(oen), 128'(1'b1));
        checkOutput("b2b_f2_odata", odata, F_HIGH);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("b2b_end_oen", 128'(oen), 128'(1'b0));

        // Held mode with junk beats while stalled.
        fct = 1'b0;
        applyStimulus(1'b1, 32'd1, 32'd2);
        applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd4, 32'd8);
        checkOutput("hold_oen", 128'(oen), 128'(1'b1));
        checkOutput("hold_full", 128'(full), 128'(1'b1));
        checkOutput("hold_odata", odata, F_1248);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'hdead0000 + 32'(i), 32'hbeef0000 + 32'(i));
            checkOutput("hold_stall_oen", 128'(oen), 128'(1'b1));
            checkOutput("hold_stall_full", 128'(full), 128'(1'b1));
            checkOutput("hold_stall_odata", odata, F_1248);
        end
        ordy = 1'b1;
        applyStimulus(1'b1, 32'hdeadbeef, 32'hdeadbeef);
        checkOutput("hold_release_oen", 128'(oen), 128'(1'b0));
        checkOutput("hold_release_full", 128'(full), 128'(1'b0));
        ordy = 1'b0;
        fct  = 1'b1;
        applyStimulus(1'b1, 32'd3, 32'd5);
        checkOutput("post_hold_b1_oen", 128'(oen), 128'(1'b0));
        applyStimulus(1'b1, 32'd7, 32'd11);
        checkOutput("post_hold_oen", 128'(oen), 128'(1'b1));
        checkOutput("post_hold_odata", odata, F_35711);
        applyStimulus(1'b0, 32'd0, 32'd0);

        // Minimum held width: ordy already high on the first HOLD edge.
        fct  = 1'b0;
        ordy = 1'b1;
        applyStimulus(1'b1, 32'd1, 32'd1);
        applyStimulus(1'b1, 32'd2, 32'd2);
        checkOutput("minhold_oen", 128'(oen), 128'(1'b1));
        checkOutput("minhold_full", 128'(full), 128'(1'b1));
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("minhold_drop_oen", 128'(oen), 128'(1'b0));
        checkOutput("minhold_drop_full", 128'(full), 128'(1'b0));
        ordy = 1'b0;

        // Reset while holding.
        applyStimulus(1'b1, 32'd5, 32'd6);
        applyStimulus(1'b1, 32'd7, 32'd8);
        checkOutput("rsthold_full_before", 128'(full), 128'(1'b1));
        ien = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rsthold_oen", 128'(oen), 128'(1'b0));
        checkOutput("rsthold_full", 128'(full), 128'(1'b0));
        checkOutput("rsthold_odata", odata, 128'd0);
        tick();
        rst = 1'b0;
        tick();

        // Mode switch mid-frame: fct only matters at completion.
        fct = 1'b1;
        applyStimulus(1'b1, 32'd10, 32'd20);
        fct = 1'b0;
        applyStimulus(1'b1, 32'd30, 32'd40);
        checkOutput("switch_full", 128'(full), 128'(1'b1));
        checkOutput("switch_odata", odata, {32'd10, 32'd20, 32'd30, 32'd40});
        ordy = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("switch_release_full", 128'(full), 128'(1'b0));
        ordy = 1'b0;
        fct  = 1'b1;
        applyStimulus(1'b1, 32'd1, 32'd1);
        applyStimulus(1'b1, 32'd2, 32'd2);
        checkOutput("switch_free_oen", 128'(oen), 128'(1'b1));
        checkOutput("switch_free_full", 128'(full), 128'(1'b0));
        checkOutput("switch_free_odata", odata, F_1122);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("switch_free_end_oen", 128'(oen), 128'(1'b0));
        checkOutput("switch_free_end_full", 128'(full), 128'(1'b0));

        // N_BEATS = 1: every beat is a frame.
        ien_n1   = 1'b1;
        idata_n1 = {32'ha, 32'hb, 32'hc, 32'hd};
        tick();
        checkOutput("n1_f1_oen", 128'(oen_n1), 128'(1'b1));
        checkOutput("n1_f1_odata", odata_n1, {32'ha, 32'hb, 32'hc, 32'hd});
        idata_n1 = {32'h1, 32'h22, 32'h333, 32'h4444};
        tick();
        checkOutput("n1_f2_oen", 128'(oen_n1), 128'(1'b1));
        checkOutput("n1_f2_odata", odata_n1, {32'h1, 32'h22, 32'h333, 32'h4444});
        ien_n1 = 1'b0;
        tick();
        checkOutput("n1_idle_oen", 128'(oen_n1), 128'(1'b0));

        // SERIAL_LENGTH = 1: four single-word beats, order preserved.
        ien_s1 = 1'b1;
        idata_s1[0] = 32'd10;
        tick();
        checkOutput("s1_b1_oen", 128'(oen_s1), 128'(1'b0));
        idata_s1[0] = 32'd20;
        tick();
        idata_s1[0] = 32'd30;
        tick();
        checkOutput("s1_b3_oen", 128'(oen_s1), 128'(1'b0));
        idata_s1[0] = 32'd40;
        tick();
        checkOutput("s1_oen", 128'(oen_s1), 128'(1'b1));
        checkOutput("s1_odata", odata_s1, {32'd10, 32'd20, 32'd30, 32'd40});
        ien_s1 = 1'b0;
        tick();
        checkOutput("s1_end_oen", 128'(oen_s1), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s_to_p_converter.md
# s_to_p_converter

Serial-to-parallel word assembler; the inverse of the parallel-to-serial converter in the datapath. Collects `PARALLEL_LENGTH/SERIAL_LENGTH` input beats of `SERIAL_LENGTH` 32-bit words each and presents them as one `PARALLEL_LENGTH`-word frame. Sits between a narrow serial stream producer and a wide parallel consumer. Supports two modes:
- free-running: single-cycle output pulse;
- held: output holds until acknowledged.

## Interface
Parameters:
- `SERIAL_LENGTH`, default 2: words per input beat; must be ≥1.
- `PARALLEL_LENGTH`, default 4: words per output frame; must be an integer multiple of `SERIAL_LENGTH` (elaboration-time assertion).

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `ien`  in  1: input beat valid.
- `idata`  in  `[0:SERIAL_LENGTH-1][31:0]`: input beat; word 0 first in frame order.
- `fct`  in  1: mode; 1 = free-running, 0 = held.
- `ordy`  in  1: consumer acknowledge; used only in held mode.
- `oen`  out  1: output frame valid.
- `odata`  out  `[0:PARALLEL_LENGTH-1][31:0]`: assembled frame.
- `full`  out  1: frame held, input stalled; upstream must not assert `ien`.

## Operation
- `N_BEATS = PARALLEL_LENGTH/SERIAL_LENGTH`. Beat counter `cnt`, range `0..N_BEATS-1`. Assembly buffer `abuf` of `PARALLEL_LENGTH` words.
- Reset values: `cnt=0`, `abuf=0`, `odata=0`, `oen=0`, `full=0`, state COLLECT.
- COLLECT, `ien=1`, `cnt<N_BEATS-1`:
  - `abuf[cnt*SERIAL_LENGTH +: SERIAL_LENGTH] <= idata`
  - `cnt++`
- COLLECT, `ien=1`, `cnt==N_BEATS-1` (completion beat):
  - `odata <=` `abuf` with the final slot replaced by the current `idata`.
  - `cnt <= 0`, `oen <= 1`.
  - `fct` is sampled on this edge only. `fct=1`: stay in COLLECT. `fct=0`: go to HOLD and set `full <= 1`.
- COLLECT, `ien=0`: no change. Gaps between beats of any length are allowed.
- Free-running: `oen` high for exactly one cycle, then cleared. A completion beat on the very next frame re-asserts it; back-to-back frames are legal with `N_BEATS=1`.
- HOLD:
  - `odata` and `oen=1` are stable.
  - `ien` beats are ignored: not written, `cnt` unchanged.
  - On an edge with `ordy=1`: `oen <= 0`, `full <= 0`, go to COLLECT. `ien` in that same cycle is still ignored.
- `ordy` is don't-care in COLLECT.
- `fct` toggling mid-frame has no effect until the completion beat.
- `abuf` is not cleared between frames; every slot is overwritten before each completion.
- Reset asserted mid-frame or in HOLD: all state returns to reset values immediately; partial frame discarded.

## Timing
- Latency: completion beat at edge k means `oen`/`odata` are valid in the cycle after edge k (registered, 1 cycle).
- Free-running throughput: one frame per `N_BEATS` accepted beats, no dead cycles.
- Held mode: the minimum `oen` width is 1 cycle, when `ordy` is already high at the first HOLD edge. The next beat can be accepted on the edge after release.
- `full` rises together with `oen` and falls together with `oen`.
- No combinational input-to-output paths.

## Structure
- Shared package `s_to_p_pkg`:
  - `typedef logic [31:0] word_t`
  - state enum `{COLLECT, HOLD}`
- `N_BEATS` is a localparam derived in the module.
- One sub-module, `beat_counter`: a parameterized modulo-`N` counter with `inc`, `clr`, `last` outputs. It is reusable by the parallel-to-serial side.
- Counter width is `$clog2(N_BEATS)`, minimum 1.

## Test plan
Defaults: `PARALLEL_LENGTH=4`, `SERIAL_LENGTH=2`. Beats are separated by idle cycles unless stated otherwise.

1. **Reset.** During `rst`: `oen=0`, `full=0`, `odata=0`. Reset asserted mid-frame after one beat: the next two beats form a complete frame with no stale words.
2. **Free-running, single frame.** `fct=1`; beats `{1,2}` then `{4,8}`. Expect `oen` high for exactly 1 cycle with `odata={1,2,4,8}`, `full` stays 0.
3. **Free-running, back-to-back.** `fct=1`; beats `{1,2}`, `{4,8}`, `{0x80000000,0x40000000}`, `{0x20000000,0x10000000}` on consecutive cycles. Expect two single-cycle `oen` pulses, 2 cycles apart, carrying the correct frames.
4. **Held mode.** `fct=0`; beats `{1,2}`, `{4,8}`; keep `ordy=0` for 5 cycles while driving `ien` with junk, then pulse `ordy`. Expect `oen=full=1` stable and `odata={1,2,4,8}` unchanged throughout; both drop 1 cycle after `ordy`; the junk beats are absent from the next frame.
5. **Mode switch.** Toggle `fct` 1→0 between beat 1 and beat 2. Expect HOLD entered, because `fct` is sampled at completion. Then `fct=1` with `ordy=0` after the frame: `ordy` is ignored and free-running behaviour resumes.
6. **Parameter sweep.** `SERIAL_LENGTH=PARALLEL_LENGTH=4` (`N_BEATS=1`): every `ien` produces an `oen` the next cycle. `SERIAL_LENGTH=1`, `PARALLEL_LENGTH=4`: 4 beats per frame, word order preserved.
